// File: rtl/fsqrt_arbiter.sv
// Round-robin front end that shares one fixed-latency fsqrt pipeline among NREQ ports.
// A tag shift register routes each result back into a 1-entry per-port result buffer.
module fsqrt_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_x,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [NREQ*32-1:0]   resp_y,
    output logic [31:0]          sq_x,
    input  logic [31:0]          sq_y,
    output logic                 busy
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q [NREQ];
    logic [31:0]    res_q   [NREQ];
    logic [IDW-1:0] rr_q;
    logic [LAT-1:0] tag_vld_q;
    logic [IDW-1:0] tag_id_q [LAT];

    logic           grant_c;
    logic [IDW-1:0] grant_id_c;
    logic [IDW-1:0] cand_c;

    // Round-robin search starting one past the last granted port; held off during reset.
    always_comb begin
        grant_c    = 1'b0;
        grant_id_c = '0;
        cand_c     = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand_c = IDW'((32'(rr_q) + off) % NREQ);
            if (!grant_c && rst_n && req_valid[cand_c] && (state_q[cand_c] == ST_IDLE)) begin
                grant_c    = 1'b1;
                grant_id_c = cand_c;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sq_x      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_c && (grant_id_c == IDW'(i))) begin
                req_ready[i] = 1'b1;
                sq_x         = req_x[32*i +: 32];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_y     = '0;
        busy       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i]      = (state_q[i] == ST_DONE);
            resp_y[32*i +: 32] = res_q[i];
            busy               = busy | (state_q[i] != ST_IDLE);
        end
    end

    // Tag pipe, rr pointer and per-port IDLE/BUSY/DONE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= IDW'(NREQ - 1);
            tag_vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id_q[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= ST_IDLE;
                res_q[i]   <= '0;
            end
        end else begin
            tag_vld_q[0] <= grant_c;
            tag_id_q[0]  <= grant_id_c;
            for (int s = 1; s < LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
            if (grant_c) begin
                rr_q <= grant_id_c;
            end
            for (int i = 0; i < NREQ; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (grant_c && (grant_id_c == IDW'(i))) begin
                            state_q[i] <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == IDW'(i))) begin
                            state_q[i] <= ST_DONE;
                            res_q[i]   <= sq_y;
                        end
                    end
                    ST_DONE: begin
                        if (resp_ready[i]) begin
                            state_q[i] <= ST_IDLE;
                        end
                    end
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Bench for fsqrt_arbiter: behavioural fsqrt pipe, directed tables/sequences and a
// randomized run against a port-level reference model (pending flag + ready cycle).
module tb_fsqrt_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_x = '0;
    logic [NREQ-1:0]     resp_valid;
    logic [NREQ-1:0]     resp_ready = '0;
    logic [NREQ*32-1:0]  resp_y;
    logic [31:0]         sq_x;
    logic [31:0]         sq_y;
    logic                busy;

    fsqrt_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .sq_x       (sq_x),
        .sq_y       (sq_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Single-precision sqrt through double arithmetic (mantissa truncated); 0/neg/denorm -> 0.
    function automatic logic [31:0] fsqrt_f(input logic [31:0] x);
        logic [63:0] d;
        real         r;
        if (x[31] || (x[30:23] == 8'h00)) return 32'h0;
        if (x[30:23] == 8'hFF) return x;
        d = {1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
        r = $sqrt($bitstoreal(d));
        d = $realtobits(r);
        return {1'b0, 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Stand-in fsqrt unit: fixed LAT stages, no reset, no stall.
    logic [31:0] sq_p [LAT];
    always_ff @(posedge clk) begin
        sq_p[0] <= fsqrt_f(sq_x);
        for (int s = 1; s < LAT; s++) sq_p[s] <= sq_p[s-1];
    end
    assign sq_y = sq_p[LAT-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0]     xr    [NREQ];
    logic [NREQ-1:0] pend;
    int              avail [NREQ];
    logic [31:0]     ey    [NREQ];
    int              rr_m;
    int              cyc = 0;
    int              waitc [NREQ];
    int              maxw;

    logic [NREQ-1:0] last_rdy, last_rv;
    logic            last_busy;
    logic [31:0]     last_y [NREQ];

    task automatic tick(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r);
        int              g;
        logic [NREQ-1:0] e_rdy, e_rv;
        logic [31:0]     e_sqx;
        req_valid  = v;
        resp_ready = r;
        for (int i = 0; i < NREQ; i++) req_x[32*i +: 32] = xr[i];
        @(negedge clk);
        e_rv = '0;
        for (int i = 0; i < NREQ; i++) if (pend[i] && cyc >= avail[i]) e_rv[i] = 1'b1;
        g = -1;
        for (int off = 1; off <= NREQ; off++) begin
            int i;
            i = (rr_m + off) % NREQ;
            if (g < 0 && v[i] && !pend[i]) g = i;
        end
        e_rdy = '0;
        e_sqx = '0;
        if (g >= 0) begin
            e_rdy[g] = 1'b1;
            e_sqx    = xr[g];
        end
        last_rdy  = req_ready;
        last_rv   = resp_valid;
        last_busy = busy;
        for (int i = 0; i < NREQ; i++) last_y[i] = resp_y[32*i +: 32];
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("busy", 32'(busy), 32'(pend != '0));
        chk("sq_x", sq_x, e_sqx);
        for (int i = 0; i < NREQ; i++) begin
            if (e_rv[i]) chk($sformatf("resp_y[%0d]", i), last_y[i], ey[i]);
            if (v[i] && !pend[i] && !req_ready[i]) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > maxw) maxw = waitc[i];
        end
        for (int i = 0; i < NREQ; i++) if (e_rv[i] && r[i]) pend[i] = 1'b0;
        if (g >= 0) begin
            pend[g]  = 1'b1;
            avail[g] = cyc + LAT + 1;
            ey[g]    = fsqrt_f(xr[g]);
            rr_m     = g;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One-cycle async reset with requests pending on every port.
    task automatic do_reset();
        req_valid = '1;
        rst_n     = 1'b0;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < NREQ; i++) chk("rst_resp_y", resp_y[32*i +: 32], 32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        pend      = '0;
        rr_m      = NREQ - 1;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        cyc++;
    endtask

    typedef struct {
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] e_rdy;
        logic [NREQ-1:0] e_rv;
        logic            e_busy;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] tbl_y [NREQ];
    int          grants [$];
    int          ngr;
    logic [31:0] held_y;

    initial begin
        tbl[0] = '{4'hF, 4'h0, 4'h1, 4'h0, 1'b0};
        tbl[1] = '{4'hE, 4'h0, 4'h2, 4'h0, 1'b1};
        tbl[2] = '{4'hC, 4'h0, 4'h4, 4'h0, 1'b1};
        tbl[3] = '{4'h8, 4'h0, 4'h8, 4'h0, 1'b1};
        tbl[4] = '{4'h0, 4'hF, 4'h0, 4'h1, 1'b1};
        tbl[5] = '{4'h0, 4'hF, 4'h0, 4'h2, 1'b1};
        tbl[6] = '{4'h0, 4'hF, 4'h0, 4'h4, 1'b1};
        tbl[7] = '{4'h0, 4'hF, 4'h0, 4'h8, 1'b1};
        tbl[8] = '{4'h0, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl_y[0] = 32'h3F800000;
        tbl_y[1] = 32'h40000000;
        tbl_y[2] = 32'h40400000;
        tbl_y[3] = 32'h40800000;
        for (int i = 0; i < NREQ; i++) begin
            xr[i] = '0; ey[i] = '0; avail[i] = 0; waitc[i] = 0;
        end
        pend = '0;
        rr_m = NREQ - 1;
        maxw = 0;

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single op on port 0 with x = 0
        xr[0] = 32'h0;
        tick(4'h1, 4'h0);
        chk("single_grant", 32'(last_rdy), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            tick(4'h0, 4'h0);
            chk("single_busy", 32'(last_busy), 32'h1);
            chk("single_no_resp", 32'(last_rv), 32'h0);
        end
        tick(4'h0, 4'h0);
        chk("single_resp_valid", 32'(last_rv), 32'h1);
        chk("single_resp_y", last_y[0], 32'h0);
        tick(4'h0, 4'h1);
        chk("single_held", 32'(last_rv), 32'h1);
        tick(4'h0, 4'h0);
        chk("single_busy_clear", 32'(last_busy), 32'h0);

        // Contention table: squares 1,4,9,16 on ports 0..3
        do_reset();
        xr[0] = 32'h3F800000; xr[1] = 32'h40800000;
        xr[2] = 32'h41100000; xr[3] = 32'h41800000;
        for (int t = 0; t < 9; t++) begin
            tick(tbl[t].v, tbl[t].r);
            chk($sformatf("tbl%0d_req_ready", t), 32'(last_rdy), 32'(tbl[t].e_rdy));
            chk($sformatf("tbl%0d_resp_valid", t), 32'(last_rv), 32'(tbl[t].e_rv));
            chk($sformatf("tbl%0d_busy", t), 32'(last_busy), 32'(tbl[t].e_busy));
            for (int i = 0; i < NREQ; i++)
                if (tbl[t].e_rv[i]) chk($sformatf("tbl%0d_resp_y%0d", t, i), last_y[i], tbl_y[i]);
        end

        // Back-pressure on port 2 while the others keep issuing
        tick(4'h4, 4'hB);
        ngr = 0;
        held_y = 32'h0;
        for (int t = 1; t <= 20; t++) begin
            tick(4'hF, 4'hB);
            chk("bp_req_ready2", 32'(last_rdy[2]), 32'h0);
            if (last_rdy != '0) ngr++;
            if (t == 4) held_y = last_y[2];
            if (t > 4) chk("bp_resp_y2_held", last_y[2], held_y);
        end
        chk("bp_resp_valid2", 32'(last_rv[2]), 32'h1);
        chk("bp_resp_y2", last_y[2], 32'h40400000);
        chk("bp_other_grants", 32'(ngr >= 10), 32'h1);
        for (int t = 0; t < 8; t++) tick(4'h0, 4'hF);

        // Fairness between ports 0 and 2
        do_reset();
        maxw = 0;
        grants.delete();
        for (int t = 0; t < 20; t++) begin
            xr[0] = 32'h3F800000 + 32'(t);
            xr[2] = 32'h41100000 + 32'(t);
            tick(4'h5, 4'hF);
            for (int i = 0; i < NREQ; i++) if (last_rdy[i]) grants.push_back(i);
        end
        chk("fair_count", 32'(grants.size() >= 4), 32'h1);
        if (grants.size() >= 4) begin
            chk("fair_g0", 32'(grants[0]), 32'd0);
            chk("fair_g1", 32'(grants[1]), 32'd2);
            chk("fair_g2", 32'(grants[2]), 32'd0);
            chk("fair_g3", 32'(grants[3]), 32'd2);
        end
        chk("fair_max_wait", 32'(maxw <= NREQ), 32'h1);
        for (int t = 0; t < 6; t++) tick(4'h0, 4'hF);

        // Reset mid-flight
        tick(4'h7, 4'hF);
        tick(4'h6, 4'hF);
        tick(4'h4, 4'hF);
        tick(4'h0, 4'hF);
        tick(4'h0, 4'hF);
        do_reset();
        for (int t = 0; t < 10; t++) begin
            tick(4'h0, 4'hF);
            chk("postrst_no_resp", 32'(last_rv), 32'h0);
        end
        xr[3] = 32'h41800000;
        tick(4'h8, 4'h0);
        chk("postrst_grant3", 32'(last_rdy), 32'h8);
        repeat (3) tick(4'h0, 4'h0);
        tick(4'h0, 4'hF);
        chk("postrst_resp_valid3", 32'(last_rv), 32'h8);
        chk("postrst_resp_y3", last_y[3], 32'h40800000);

        // Randomized traffic against the reference model
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 9) == 0) xr[i] = 32'h0;
                else xr[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            end
            tick(4'($urandom), 4'($urandom) | 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
